// File: rtl/add_window_acc_if.sv
// Handshake bundle between the adder stage, the window accumulator and its consumer.
// Carries the incoming z sample channel and the outgoing window result channel.
interface add_window_acc_if #(
  parameter int unsigned ZW    = 4,
  parameter int unsigned ACC_W = 8
);

  // Sample channel from the adder stage
  logic             z_valid;
  logic             z_ready;
  logic [ZW-1:0]    z_data;

  // Window result channel to the checker/scoreboard
  logic             sum_valid;
  logic             sum_ready;
  logic [ACC_W-1:0] sum_data;
  logic [ZW-1:0]    max_data;

  // Progress through the current window
  logic [7:0]       win_cnt;

  // Producer of samples / consumer of results
  modport master (
    output z_valid,
    output z_data,
    output sum_ready,
    input  z_ready,
    input  sum_valid,
    input  sum_data,
    input  max_data,
    input  win_cnt
  );

  // The window accumulator itself
  modport slave (
    input  z_valid,
    input  z_data,
    input  sum_ready,
    output z_ready,
    output sum_valid,
    output sum_data,
    output max_data,
    output win_cnt
  );

endinterface

// File: rtl/add_window_acc.sv
// Window accumulator for the adder's z stream: sums N_SAMPLES samples with
// saturation, tracks the window maximum and hands both out over valid/ready.
// Optional macro ADD_WINDOW_ACC_SKID_EN adds a one-entry result buffer so the
// next window keeps accumulating while the previous result waits.
module add_window_acc #(
  parameter int unsigned ZW        = 4,
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  add_window_acc_if.slave  bus
);

  localparam int unsigned    SUM_W    = ACC_W + 1;
  localparam logic [7:0]     LAST_CNT = 8'(N_SAMPLES - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  // HOLD: a result is presented; FULL (skid only): a second result is buffered
  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_HOLD  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;

  logic [ACC_W-1:0] acc_q;
  logic [ZW-1:0]    max_q;
  logic [7:0]       cnt_q;

  logic             valid_q;
  logic [ACC_W-1:0] sum_q;
  logic [ZW-1:0]    maxo_q;

`ifdef ADD_WINDOW_ACC_SKID_EN
  logic [ACC_W-1:0] buf_sum_q;
  logic [ZW-1:0]    buf_max_q;
  logic             load_buf;
  logic             load_from_buf;
`endif

  logic             accept_open;
  logic             z_ready_c;
  logic             z_fire;
  logic             s_fire;
  logic             last;
  logic             load_out;

  logic [SUM_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_nxt;
  logic [ZW-1:0]    max_nxt;

  // Sample intake is open in ACCUM, and also in HOLD when a buffer slot is free
`ifdef ADD_WINDOW_ACC_SKID_EN
  assign accept_open = (state_q == S_ACCUM) || (state_q == S_HOLD);
`else
  assign accept_open = (state_q == S_ACCUM);
`endif

  // Handshake qualifiers; z_ready drops immediately while rst is high
  assign z_ready_c = !rst && accept_open;
  assign z_fire    = bus.z_valid && z_ready_c;
  assign s_fire    = valid_q && bus.sum_ready;
  assign last      = z_fire && (cnt_q == LAST_CNT);

  // Saturating add and running maximum including the current sample
  assign sum_ext = SUM_W'(acc_q) + SUM_W'(bus.z_data);
  assign acc_nxt = sum_ext[ACC_W] ? ACC_MAX : sum_ext[ACC_W-1:0];
  assign max_nxt = (bus.z_data > max_q) ? bus.z_data : max_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACCUM: begin
        if (last) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
`ifdef ADD_WINDOW_ACC_SKID_EN
        if (last && !s_fire) begin
          state_d = S_FULL;
        end else if (s_fire && !last) begin
          state_d = S_ACCUM;
        end
`else
        if (s_fire) begin
          state_d = S_ACCUM;
        end
`endif
      end
`ifdef ADD_WINDOW_ACC_SKID_EN
      S_FULL: begin
        if (s_fire) begin
          state_d = S_HOLD;
        end
      end
`endif
      default: state_d = S_ACCUM;
    endcase
  end

  // Output/control decode: when the result register and buffer load
  always_comb begin
    load_out      = 1'b0;
`ifdef ADD_WINDOW_ACC_SKID_EN
    load_buf      = 1'b0;
    load_from_buf = 1'b0;
`endif
    unique case (state_q)
      S_ACCUM: load_out = last;
`ifdef ADD_WINDOW_ACC_SKID_EN
      // A window finishing while the old result leaves goes straight out
      S_HOLD: begin
        load_out = last && s_fire;
        load_buf = last && !s_fire;
      end
      // Buffered result moves up as soon as the presented one is taken
      S_FULL: begin
        load_out      = s_fire;
        load_from_buf = 1'b1;
      end
`endif
      default: load_out = 1'b0;
    endcase
  end

  // Window accumulator, running max and sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (z_fire) begin
      if (last) begin
        acc_q <= '0;
        max_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_nxt;
        max_q <= max_nxt;
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Presented result; held stable until it transfers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      maxo_q  <= '0;
    end else begin
      valid_q <= (state_d != S_ACCUM);
      if (load_out) begin
`ifdef ADD_WINDOW_ACC_SKID_EN
        sum_q  <= load_from_buf ? buf_sum_q : acc_nxt;
        maxo_q <= load_from_buf ? buf_max_q : max_nxt;
`else
        sum_q  <= acc_nxt;
        maxo_q <= max_nxt;
`endif
      end
    end
  end

`ifdef ADD_WINDOW_ACC_SKID_EN
  // One-entry skid buffer for a window completed behind a pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_sum_q <= '0;
      buf_max_q <= '0;
    end else if (load_buf) begin
      buf_sum_q <= acc_nxt;
      buf_max_q <= max_nxt;
    end
  end
`endif

  assign bus.z_ready   = z_ready_c;
  assign bus.sum_valid = valid_q;
  assign bus.sum_data  = sum_q;
  assign bus.max_data  = maxo_q;
  assign bus.win_cnt   = cnt_q;

endmodule

// File: tb/tb_add_window_acc.sv
// Bench for add_window_acc: two instances (ACC_W=8 and ACC_W=5) share one
// stimulus stream; a queue-based reference model predicts handshakes and results.
module tb_add_window_acc;

  localparam int N = 4;
`ifdef ADD_WINDOW_ACC_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  add_window_acc_if #(.ZW(4), .ACC_W(8)) ia ();
  add_window_acc_if #(.ZW(4), .ACC_W(5)) ib ();

  add_window_acc #(.ZW(4), .N_SAMPLES(N), .ACC_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  add_window_acc #(.ZW(4), .N_SAMPLES(N), .ACC_W(5)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  int checks = 0;
  int errors = 0;

  // Model: samples of the open window, and unconsumed results in order
  int win_q[$];
  int res_sum[$];
  int res_max[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic drive(input logic r, input logic zv, input logic [3:0] zd, input logic sr);
    rst          = r;
    ia.z_valid   = zv;
    ib.z_valid   = zv;
    ia.z_data    = zd;
    ib.z_data    = zd;
    ia.sum_ready = sr;
    ib.sum_ready = sr;
  endtask

  // One clock: drive, check outputs against the model, clock, update the model
  task automatic step(input logic r, input logic zv, input logic [3:0] zd, input logic sr);
    logic er;
    logic ev;
    int   s;
    int   m;
    drive(r, zv, zd, sr);
    #1;
    er = !r && (res_sum.size() < CAP);
    ev = (res_sum.size() > 0);
    chk("z_ready_a", 32'(ia.z_ready), 32'(er));
    chk("z_ready_b", 32'(ib.z_ready), 32'(er));
    chk("sum_valid_a", 32'(ia.sum_valid), 32'(ev));
    chk("sum_valid_b", 32'(ib.sum_valid), 32'(ev));
    chk("win_cnt", 32'(ia.win_cnt), 32'(win_q.size()));
    if (ev) begin
      chk("sum_data_a", 32'(ia.sum_data), 32'(sat(res_sum[0], 8)));
      chk("sum_data_b", 32'(ib.sum_data), 32'(sat(res_sum[0], 5)));
      chk("max_data_a", 32'(ia.max_data), 32'(res_max[0]));
      chk("max_data_b", 32'(ib.max_data), 32'(res_max[0]));
    end
    @(posedge clk);
    if (r) begin
      win_q.delete();
      res_sum.delete();
      res_max.delete();
    end else begin
      if (ev && sr) begin
        void'(res_sum.pop_front());
        void'(res_max.pop_front());
      end
      if (zv && er) begin
        win_q.push_back(int'(zd));
        if (win_q.size() == N) begin
          s = 0;
          m = 0;
          foreach (win_q[i]) begin
            s += win_q[i];
            if (win_q[i] > m) m = win_q[i];
          end
          res_sum.push_back(s);
          res_max.push_back(m);
          win_q.delete();
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic sr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom_range(0, 15)), sr);
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    // Reset state, with rst still high
    chk("rst_z_ready", 32'(ia.z_ready), 32'd0);
    chk("rst_sum_valid", 32'(ia.sum_valid), 32'd0);
    chk("rst_sum_data", 32'(ia.sum_data), 32'd0);
    chk("rst_max_data", 32'(ia.max_data), 32'd0);
    chk("rst_win_cnt", 32'(ia.win_cnt), 32'd0);

    // Windowed sum with the consumer always ready
    step(1'b0, 1'b1, 4'd12, 1'b1);
    step(1'b0, 1'b1, 4'd14, 1'b1);
    step(1'b0, 1'b1, 4'd6, 1'b1);
    step(1'b0, 1'b1, 4'd12, 1'b1);
    chk("win_sum_valid", 32'(ia.sum_valid), 32'd1);
    chk("win_sum", 32'(ia.sum_data), 32'd44);
    chk("win_max", 32'(ia.max_data), 32'd14);
    chk("win_cnt0", 32'(ia.win_cnt), 32'd0);
    chk("win_sum_sat5", 32'(ib.sum_data), 32'd31);
    idle(3, 1'b1);

    // Backpressure: result held for 5 cycles, then released
    step(1'b0, 1'b1, 4'd12, 1'b0);
    step(1'b0, 1'b1, 4'd14, 1'b0);
    step(1'b0, 1'b1, 4'd6, 1'b0);
    step(1'b0, 1'b1, 4'd12, 1'b0);
    idle(5, 1'b0);
    chk("bp_sum_held", 32'(ia.sum_data), 32'd44);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("bp_released", 32'(ia.sum_valid), 32'd0);
    chk("bp_ready", 32'(ia.z_ready), 32'd1);
    idle(2, 1'b1);

    // Saturation on the narrow instance
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'd15, 1'b1);
    chk("sat_sum_b", 32'(ib.sum_data), 32'd31);
    chk("sat_max_b", 32'(ib.max_data), 32'd15);
    chk("sat_sum_a", 32'(ia.sum_data), 32'd60);
    idle(2, 1'b1);

    // Gapped input
    step(1'b0, 1'b1, 4'd3, 1'b1);
    idle(2, 1'b1);
    chk("gap_cnt1", 32'(ia.win_cnt), 32'd1);
    step(1'b0, 1'b1, 4'd5, 1'b1);
    step(1'b0, 1'b1, 4'd0, 1'b1);
    idle(1, 1'b1);
    chk("gap_cnt3", 32'(ia.win_cnt), 32'd3);
    step(1'b0, 1'b1, 4'd1, 1'b1);
    chk("gap_sum", 32'(ia.sum_data), 32'd9);
    chk("gap_max", 32'(ia.max_data), 32'd5);
    idle(2, 1'b1);

    // Reset mid-window discards the partial window
    step(1'b0, 1'b1, 4'd7, 1'b1);
    step(1'b0, 1'b1, 4'd6, 1'b1);
    step(1'b1, 1'b1, 4'd9, 1'b1);
    chk("mid_rst_cnt", 32'(ia.win_cnt), 32'd0);
    step(1'b0, 1'b1, 4'd1, 1'b1);
    step(1'b0, 1'b1, 4'd2, 1'b1);
    step(1'b0, 1'b1, 4'd3, 1'b1);
    step(1'b0, 1'b1, 4'd4, 1'b1);
    chk("mid_rst_sum", 32'(ia.sum_data), 32'd10);
    chk("mid_rst_max", 32'(ia.max_data), 32'd4);
    idle(2, 1'b1);

    // Stream of 2s against a stalled consumer, then drain
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'd2, 1'b0);
    idle(4, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 9) < 7),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 9) < 6));
    end
    idle(12, 1'b1);
    chk("drained", 32'(res_sum.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
